// File: rtl/rwl_bitserial_drv.sv
// rwl_bitserial_drv: bit-serial read-wordline driver, one masked activation bit-plane per cycle, LSB first.
// Optional RWL_ZERO_SKIP_EN skips all-zero planes except the final plane.
module rwl_bitserial_drv #(
  parameter int ROWS = 64,
  parameter int IN_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ROWS*IN_W-1:0] xin,
  input  logic [ROWS-1:0]      row_en,
  output logic [ROWS-1:0]      rwlb,
  output logic                 bit_valid,
  output logic [$clog2(IN_W)-1:0] bit_idx,
  output logic                 bit_last,
  input  logic                 out_ready,
  output logic                 busy
);
  localparam int IDX_W = $clog2(IN_W);
  typedef enum logic {IDLE, DRIVE} state_t;
  state_t              state_q, state_d;
  logic [ROWS*IN_W-1:0] xin_q, xin_d;
  logic [ROWS-1:0]      en_q, en_d, rwlb_q, rwlb_d;
  logic [IDX_W-1:0]     idx_q, idx_d, cap_idx, adv_idx;
  logic                 last_q, last_d;
  function automatic logic [ROWS-1:0] plane(input logic [ROWS*IN_W-1:0] x, input logic [ROWS-1:0] en, input int b);
    for (int r = 0; r < ROWS; r++) plane[r] = en[r] & x[r*IN_W+b];
  endfunction
`ifdef RWL_ZERO_SKIP_EN
  // First non-zero plane at or after s; the final plane is always a candidate so bit_last is never skipped.
  function automatic logic [IDX_W-1:0] nxt(input logic [ROWS*IN_W-1:0] x, input logic [ROWS-1:0] en, input int s);
    nxt = IDX_W'(IN_W-1);
    for (int i = IN_W-2; i >= 0; i--) if (i >= s && (|plane(x, en, i))) nxt = IDX_W'(i);
  endfunction
  assign cap_idx = nxt(xin, row_en, 0);
  assign adv_idx = nxt(xin_q, en_q, int'(idx_q) + 1);
`else
  assign cap_idx = '0;
  assign adv_idx = idx_q + 1'b1;
`endif
  always_comb begin
    state_d = state_q;
    xin_d   = xin_q;
    en_d    = en_q;
    idx_d   = idx_q;
    rwlb_d  = rwlb_q;
    last_d  = last_q;
    if (state_q == IDLE && in_valid) begin
      state_d = DRIVE;
      xin_d   = xin;
      en_d    = row_en;
      idx_d   = cap_idx;
      rwlb_d  = plane(xin, row_en, int'(cap_idx));
      last_d  = cap_idx == IDX_W'(IN_W-1);
    end else if (state_q == DRIVE && out_ready) begin
      state_d = last_q ? IDLE : DRIVE;
      idx_d   = last_q ? '0 : adv_idx;
      rwlb_d  = last_q ? '0 : plane(xin_q, en_q, int'(adv_idx));
      last_d  = !last_q && adv_idx == IDX_W'(IN_W-1);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      xin_q   <= '0;
      en_q    <= '0;
      idx_q   <= '0;
      rwlb_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      xin_q   <= xin_d;
      en_q    <= en_d;
      idx_q   <= idx_d;
      rwlb_q  <= rwlb_d;
      last_q  <= last_d;
    end
  end
  assign in_ready  = state_q == IDLE;
  assign busy      = state_q == DRIVE;
  assign bit_valid = state_q == DRIVE;
  assign rwlb      = rwlb_q;
  assign bit_idx   = idx_q;
  assign bit_last  = last_q;
endmodule

// File: tb/tb_rwl_bitserial_drv.sv
// tb_rwl_bitserial_drv: randomized scoreboard bench for rwl_bitserial_drv at ROWS=4, IN_W=4.
module tb_rwl_bitserial_drv;
  localparam int R = 4;
  localparam int W = 4;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 1;
  logic [R*W-1:0] xin = '0;
  logic [R-1:0] row_en = '0, rwlb;
  logic in_ready, bit_valid, bit_last, busy;
  logic [1:0] bit_idx;
  int total = 0, bad = 0, or_mode = 0;
  bit chk_bubble = 0;
  typedef struct {logic [R-1:0] rwlb; logic [1:0] idx; logic last;} exp_t;
  exp_t q[$];
  rwl_bitserial_drv #(.ROWS(R), .IN_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .xin(xin), .row_en(row_en),
    .rwlb(rwlb), .bit_valid(bit_valid), .bit_idx(bit_idx), .bit_last(bit_last), .out_ready(out_ready), .busy(busy)
  );
  always #5 clk = ~clk;
  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask
  // Reference: each row contributes bit b of its activation if selected; planes in order 0..W-1.
  task automatic push_frame(input logic [R*W-1:0] x, input logic [R-1:0] en);
    for (int b = 0; b < W; b++) begin
      exp_t e;
      int v = 0;
      for (int r = 0; r < R; r++) if (en[r] && ((x >> (r*W + b)) & 1)) v += (1 << r);
`ifdef RWL_ZERO_SKIP_EN
      if (v == 0 && b != W-1) continue;
`endif
      e.rwlb = R'(v);
      e.idx  = 2'(b);
      e.last = (b == W-1);
      q.push_back(e);
    end
  endtask
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      chk_bubble = 0;
    end else begin
      if (chk_bubble) chk("bubble_in_ready", {in_ready, bit_valid}, 2'b10);
      chk_bubble = 0;
      if (!bit_valid) chk("idle_rwlb", rwlb, 0);
      else if (q.size() == 0) chk("unexpected_plane", bit_valid, 0);
      else begin
        chk("plane_rwlb", rwlb, q[0].rwlb);
        chk("plane_idx", bit_idx, q[0].idx);
        chk("plane_last", bit_last, q[0].last);
        chk("drive_busy_ready", {busy, in_ready}, 2'b10);
        if (out_ready) begin
          void'(q.pop_front());
          if (bit_last) chk_bubble = 1;
        end
      end
      if (in_valid && in_ready) push_frame(xin, row_en);
    end
  end
  always @(posedge clk) begin
    #1;
    if (or_mode == 1) out_ready = 1'($urandom_range(0, 1));
    else if (or_mode == 0) out_ready = 1;
  end
  task automatic send(input logic [R*W-1:0] x, input logic [R-1:0] en, input bit junk);
    bit ok;
    int n = 0;
    in_valid = 1;
    xin = x;
    row_en = en;
    do begin
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 200);
    if (!ok) chk("accept_timeout", 0, 1);
    if (junk) begin
      xin = R*W'($urandom);
      row_en = R'($urandom);
    end else in_valid = 0;
  endtask
  task automatic drain();
    int n = 0;
    in_valid = 0;
    while ((q.size() != 0 || bit_valid) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain", q.size(), 0);
  endtask
  initial begin
    #2;
    chk("reset_outputs", {rwlb, bit_valid, bit_idx, bit_last, busy, in_ready}, 10'b0000_0_00_0_0_1);
    @(posedge clk);
    #1;
    rst_n = 1;
    send(16'h8F35, 4'b1011, 0);
    drain();
    or_mode = 2;
    out_ready = 1;
    send(16'h8F35, 4'b1011, 0);
    @(posedge clk);
    #1;
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      chk("hold_plane", {bit_valid, bit_idx, rwlb}, {1'b1, 2'd1, 4'b0010});
      @(posedge clk);
      #1;
    end
    chk("hold_plane_end", {bit_valid, bit_idx, rwlb}, {1'b1, 2'd1, 4'b0010});
    out_ready = 1;
    drain();
    or_mode = 0;
    send(16'hA5C3, 4'b1111, 1);
    send(16'hFFFF, 4'b0000, 0);
    drain();
    send(16'h4444, 4'b1111, 0);
    drain();
    send(16'h7E91, 4'b1101, 0);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 0;
    #1;
    chk("async_reset", {rwlb, bit_valid, bit_idx, bit_last, busy, in_ready}, 10'b0000_0_00_0_0_1);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1;
    send(16'h7E91, 4'b1101, 0);
    drain();
    or_mode = 1;
    for (int k = 0; k < 60; k++) begin
      logic [R*W-1:0] x = R*W'($urandom);
      logic [R-1:0] en = (k % 7 == 0) ? '0 : R'($urandom);
      send(x, en, 1'($urandom_range(0, 1)));
      if (k % 5 == 0) drain();
    end
    drain();
    or_mode = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
